// File: rtl/stereo_pkg.sv
// stereo_pkg: shared types and widths for the stereo input/output synchronizers
package stereo_pkg;
    localparam int PIX_W        = 16;
    localparam int RESYNC_CNT_W = 16;
    typedef struct packed {
        logic             tuser;
        logic             tlast;
        logic [PIX_W-1:0] data;
    } pix_beat_t;
    typedef enum logic {SEEK, STREAM} insync_state_t;
endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: first-word-fall-through skew buffer
// ports: clk/rst_n (async active-low), push/wdata write side, pop/rdata head side, full/empty flags
module axis_sync_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, rd_en;
    assign empty = wr_q == rd_q;
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign rdata = mem_q[rd_q[AW-1:0]];
    // a full buffer still takes a write in the cycle its head leaves
    always_comb begin
        rd_en = pop & !empty;
        wr_en = push & (!full | rd_en);
        wr_d  = wr_q + (AW+1)'(wr_en);
        rd_d  = rd_q + (AW+1)'(rd_en);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/in_synch.sv
// in_synch: merges left/right camera AXI-Stream inputs into one frame-aligned {R,L} stream
// ports: aclk/aresetn; s_axis_l_*/s_axis_r_* camera inputs; m_axis_* combined output;
//        resync_cnt saturating mismatch count; synced high while streaming
module in_synch
    import stereo_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [IN_WIDTH-1:0]     s_axis_l_tdata,
    input  logic                    s_axis_l_tvalid,
    output logic                    s_axis_l_tready,
    input  logic                    s_axis_l_tlast,
    input  logic                    s_axis_l_tuser,
    input  logic [IN_WIDTH-1:0]     s_axis_r_tdata,
    input  logic                    s_axis_r_tvalid,
    output logic                    s_axis_r_tready,
    input  logic                    s_axis_r_tlast,
    input  logic                    s_axis_r_tuser,
    output logic [2*IN_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic [RESYNC_CNT_W-1:0] resync_cnt,
    output logic                    synced
);
    localparam int BW = IN_WIDTH + 2;
    logic [BW-1:0]           head_l, head_r;
    logic                    full_l, full_r, empty_l, empty_r, pop_l, pop_r;
    logic                    fire, agree, load, both_sof, run_q;
    insync_state_t           state_q, state_d;
    logic [2*IN_WIDTH-1:0]   tdata_q, tdata_d;
    logic                    tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic [RESYNC_CNT_W-1:0] cnt_q, cnt_d;
    // run_q keeps both inputs stalled until the first clock after reset release
    assign s_axis_l_tready = run_q & !full_l;
    assign s_axis_r_tready = run_q & !full_r;
    axis_sync_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_fifo_l (
        .clk(aclk), .rst_n(aresetn), .push(s_axis_l_tvalid & s_axis_l_tready),
        .wdata({s_axis_l_tuser, s_axis_l_tlast, s_axis_l_tdata}), .pop(pop_l),
        .rdata(head_l), .full(full_l), .empty(empty_l)
    );
    axis_sync_fifo #(.WIDTH(BW), .DEPTH(FIFO_DEPTH)) u_fifo_r (
        .clk(aclk), .rst_n(aresetn), .push(s_axis_r_tvalid & s_axis_r_tready),
        .wdata({s_axis_r_tuser, s_axis_r_tlast, s_axis_r_tdata}), .pop(pop_r),
        .rdata(head_r), .full(full_r), .empty(empty_r)
    );
    // head layout: [BW-1]=tuser, [BW-2]=tlast, [IN_WIDTH-1:0]=pixel
    always_comb begin
        both_sof = !empty_l && !empty_r && head_l[BW-1] && head_r[BW-1];
        fire     = state_q == STREAM && !empty_l && !empty_r && (!tvalid_q || m_axis_tready);
        agree    = head_l[BW-1:BW-2] == head_r[BW-1:BW-2];
        load     = fire && agree;
        pop_l    = fire || (state_q == SEEK && !empty_l && !head_l[BW-1]);
        pop_r    = fire || (state_q == SEEK && !empty_r && !head_r[BW-1]);
        state_d  = (state_q == SEEK) ? (both_sof ? STREAM : SEEK) : ((fire && !agree) ? SEEK : STREAM);
        cnt_d    = (fire && !agree && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
        tvalid_d = load || (tvalid_q && !m_axis_tready);
        tdata_d  = load ? {head_r[IN_WIDTH-1:0], head_l[IN_WIDTH-1:0]} : tdata_q;
        tlast_d  = load ? head_l[BW-2] : tlast_q;
        tuser_d  = load ? head_l[BW-1] : tuser_q;
    end
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= SEEK;
            run_q    <= 1'b0;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= 1'b1;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
        end
    end
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign resync_cnt    = cnt_q;
    assign synced        = state_q == STREAM;
endmodule

// File: tb/tb_in_synch.sv
// tb_in_synch: directed checks of frame alignment, skew, backpressure, resync and reset
module tb_in_synch;
    logic        aclk = 1'b0, aresetn = 1'b0, mr = 1'b1, kill = 1'b0;
    logic [15:0] td [2] = '{16'h0, 16'h0};
    logic        tv [2] = '{1'b0, 1'b0};
    logic        tl [2] = '{1'b0, 1'b0};
    logic        tu [2] = '{1'b0, 1'b0};
    logic        tr_l, tr_r, m_tvalid, m_tlast, m_tuser, synced;
    logic [31:0] m_tdata;
    logic [15:0] resync_cnt;
    logic [17:0] ql[$], qr[$];
    logic [33:0] exp_q[$], got_q[$], hold_obs[$], hold_exp[$];
    logic [33:0] held = '0;
    logic        hold = 1'b0, sync_prev = 1'b0, done = 1'b0;
    int          checks = 0, errors = 0, falls = 0, idx [2];
    always #5 aclk = ~aclk;
    in_synch #(.IN_WIDTH(16), .FIFO_DEPTH(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_l_tdata(td[0]), .s_axis_l_tvalid(tv[0]), .s_axis_l_tready(tr_l),
        .s_axis_l_tlast(tl[0]), .s_axis_l_tuser(tu[0]),
        .s_axis_r_tdata(td[1]), .s_axis_r_tvalid(tv[1]), .s_axis_r_tready(tr_r),
        .s_axis_r_tlast(tl[1]), .s_axis_r_tuser(tu[1]),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(mr),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
        .resync_cnt(resync_cnt), .synced(synced)
    );
    always @(negedge aclk) begin
        if (aresetn && !kill) begin
            if (hold) begin
                hold_obs.push_back({m_tuser, m_tlast, m_tdata});
                hold_exp.push_back(held);
            end
            if (m_tvalid && mr) got_q.push_back({m_tuser, m_tlast, m_tdata});
            hold      <= m_tvalid && !mr;
            held      <= {m_tuser, m_tlast, m_tdata};
            if (sync_prev && !synced) falls <= falls + 1;
            sync_prev <= synced;
        end else begin
            hold      <= 1'b0;
            sync_prev <= 1'b0;
        end
    end
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask
    function automatic logic [15:0] pix(input int ch, input int f, input int ln, input int px);
        logic [3:0] a;
        a = (ch != 0) ? 4'h2 : 4'h1;
        return {a, 4'(f), 4'(ln), 4'(px)};
    endfunction
    task automatic add_frame(input int ch, input int f, input int bad_line);
        logic [17:0] b;
        for (int ln = 0; ln < 4; ln++) begin
            int n = (ln == bad_line) ? 7 : 8;
            for (int px = 0; px < n; px++) begin
                b = {ln == 0 && px == 0, px == n - 1, pix(ch, f, ln, px)};
                if (ch == 0) ql.push_back(b);
                else qr.push_back(b);
            end
        end
    endtask
    task automatic add_exp(input int f, input int nbeats);
        for (int k = 0; k < nbeats; k++)
            exp_q.push_back({k == 0, (k % 8) == 7, pix(1, f, k / 8, k % 8), pix(0, f, k / 8, k % 8)});
    endtask
    task automatic send(input int dly);
        int n0, n1, cyc;
        logic a0, a1;
        n0 = ql.size();
        n1 = qr.size();
        idx[0] = 0;
        idx[1] = 0;
        cyc = 0;
        done = 1'b0;
        while ((idx[0] < n0 || idx[1] < n1) && cyc < 3000 && !kill) begin
            tv[0] = idx[0] < n0;
            if (tv[0]) {tu[0], tl[0], td[0]} = ql[idx[0]];
            tv[1] = idx[1] < n1 && cyc >= dly;
            if (tv[1]) {tu[1], tl[1], td[1]} = qr[idx[1]];
            @(negedge aclk);
            a0 = tv[0] & tr_l;
            a1 = tv[1] & tr_r;
            @(posedge aclk);
            #1;
            idx[0] += int'(a0);
            idx[1] += int'(a1);
            cyc++;
        end
        tv[0] = 1'b0;
        tv[1] = 1'b0;
        if (!kill) chk("send_in_budget", cyc < 3000, 1);
        ql.delete();
        qr.delete();
        done = 1'b1;
    endtask
    task automatic wait_done();
        for (int t = 0; t < 3000 && !done; t++) @(posedge aclk);
        #1;
        chk("sender_done", done, 1);
    endtask
    task automatic drain(input int base);
        for (int t = 0; t < 1000 && got_q.size() - base < exp_q.size(); t++) @(posedge aclk);
        repeat (5) @(posedge aclk);
        #1;
    endtask
    task automatic compare(input string tag, input int base);
        int n;
        n = got_q.size() - base;
        chk({tag, "_beats"}, n, exp_q.size());
        for (int i = 0; i < n && i < exp_q.size(); i++) chk(tag, got_q[base + i], exp_q[i]);
        exp_q.delete();
    endtask
    task automatic do_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
    endtask
    initial begin
        int base, f0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_cnt", resync_cnt, 0);
        chk("rst_synced", synced, 0);
        chk("rst_tready", {tr_l, tr_r}, 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        base = got_q.size();
        add_frame(0, 0, -1);
        add_frame(1, 0, -1);
        add_exp(0, 32);
        send(0);
        drain(base);
        compare("equal", base);
        chk("equal_cnt", resync_cnt, 0);
        chk("equal_synced", synced, 1);
        do_reset();
        base = got_q.size();
        for (int g = 0; g < 3; g++) ql.push_back({2'b00, 16'hDE00 + 16'(g)});
        add_frame(0, 1, -1);
        add_frame(1, 1, -1);
        add_exp(1, 32);
        send(5);
        drain(base);
        compare("skew", base);
        chk("skew_cnt", resync_cnt, 0);
        do_reset();
        base = got_q.size();
        mr = 1'b0;
        add_frame(0, 2, -1);
        add_frame(1, 2, -1);
        add_exp(2, 32);
        fork
            send(0);
        join_none
        repeat (40) @(posedge aclk);
        #1;
        chk("stall_accept_l", idx[0], 17);
        chk("stall_accept_r", idx[1], 17);
        chk("stall_tready", {tr_l, tr_r}, 0);
        chk("stall_tvalid", m_tvalid, 1);
        for (int t = 0; t < 400 && got_q.size() - base < exp_q.size(); t++) begin
            @(posedge aclk);
            #1;
            mr = ~mr;
        end
        mr = 1'b1;
        wait_done();
        drain(base);
        compare("bp", base);
        chk("hold_seen", hold_obs.size() > 30, 1);
        for (int i = 0; i < hold_obs.size(); i++) chk("hold", hold_obs[i], hold_exp[i]);
        do_reset();
        base = got_q.size();
        f0 = falls;
        add_frame(0, 3, -1);
        add_frame(0, 4, -1);
        add_frame(1, 3, 2);
        add_frame(1, 4, -1);
        add_exp(3, 22);
        add_exp(4, 32);
        send(0);
        drain(base);
        compare("mismatch", base);
        chk("mismatch_cnt", resync_cnt, 1);
        chk("mismatch_falls", falls - f0, 1);
        chk("mismatch_resynced", synced, 1);
        do_reset();
        base = got_q.size();
        add_frame(0, 5, -1);
        add_frame(1, 5, -1);
        fork
            send(0);
        join_none
        for (int t = 0; t < 500 && got_q.size() - base < 12; t++) @(posedge aclk);
        #1;
        chk("mid_seen12", got_q.size() - base, 12);
        aresetn = 1'b0;
        kill = 1'b1;
        #1;
        chk("mid_tvalid", m_tvalid, 0);
        chk("mid_tdata", m_tdata, 0);
        chk("mid_flags", {m_tuser, m_tlast}, 0);
        chk("mid_synced", synced, 0);
        chk("mid_tready", {tr_l, tr_r}, 0);
        wait_done();
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        kill = 1'b0;
        @(posedge aclk);
        #1;
        base = got_q.size();
        add_frame(0, 6, -1);
        add_frame(1, 6, -1);
        add_exp(6, 32);
        send(0);
        drain(base);
        compare("post_reset", base);
        chk("post_reset_cnt", resync_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
